// File: rtl/sha256_ctrl_pkg.sv
// Shared types and constants for the SHA256 single-block sequencer.
package sha256_ctrl_pkg;

    localparam int unsigned SHA_ROUNDS     = 64;
    localparam int unsigned SHA_HASH_WORDS = 8;
    localparam int unsigned ROUND_W        = $clog2(SHA_ROUNDS);
    localparam int unsigned ADDR_W         = $clog2(SHA_HASH_WORDS);

    typedef enum logic [2:0] {
        StIdle,
        StPadStart,
        StPadWait,
        StLoad,
        StRound,
        StUpdate,
        StWrite,
        StDone
    } state_e;

endpackage

// File: rtl/sha256_ctrl_cnt.sv
// Up-counter with synchronous clear (priority over enable) and a decoded terminal-count flag.
module sha256_ctrl_cnt #(
    parameter int unsigned Width  = 6,
    parameter int unsigned MaxVal = 63
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o,
    output logic             tc_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == Width'(MaxVal));

endmodule

// File: rtl/sha256_ctrl.sv
// Sequencer for the SHA256 single-block datapath: pad, load, 64 rounds, update, digest write.
// Optional padder watchdog enabled by defining SHA_CTRL_TIMEOUT_EN.
module sha256_ctrl
    import sha256_ctrl_pkg::*;
#(
    parameter int unsigned MAX_MESSAGE_LENGTH = 55,
    parameter int unsigned TIMEOUT_CYCLES     = 256,
    localparam int unsigned LEN_W             = $clog2(MAX_MESSAGE_LENGTH)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              go_sig_i,
    input  logic [LEN_W-1:0]  msg_len_i,
    output logic              pad_go_o,
    output logic [LEN_W-1:0]  pad_len_o,
    input  logic              pad_rdy_i,
    output logic              sched_load_o,
    output logic              hash_init_o,
    output logic              round_en_o,
    output logic [ROUND_W-1:0] round_idx_o,
    output logic              hash_update_o,
    output logic              out_mem_en_o,
    output logic              out_mem_write_o,
    output logic [ADDR_W-1:0] out_mem_addr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    state_e state_d, state_q;
    logic   go_accept;
    logic   rnd_tc, wr_tc, timeout;
    logic [LEN_W-1:0] pad_len_d, pad_len_q;

    assign go_accept = go_sig_i && ((state_q == StIdle) || (state_q == StDone));

    sha256_ctrl_cnt #(
        .Width  (ROUND_W),
        .MaxVal (SHA_ROUNDS - 1)
    ) u_round_cnt (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clr_i   (state_q == StLoad),
        .en_i    ((state_q == StRound) && !rnd_tc),
        .cnt_o   (round_idx_o),
        .tc_o    (rnd_tc)
    );

    sha256_ctrl_cnt #(
        .Width  (ADDR_W),
        .MaxVal (SHA_HASH_WORDS - 1)
    ) u_write_cnt (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clr_i   (state_q == StUpdate),
        .en_i    ((state_q == StWrite) && !wr_tc),
        .cnt_o   (out_mem_addr_o),
        .tc_o    (wr_tc)
    );

`ifdef SHA_CTRL_TIMEOUT_EN
    localparam int unsigned WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WdW-1:0] wd_cnt;
    logic           wd_tc;
    logic           err_d, err_q;

    // Count holds TIMEOUT_CYCLES-1 on the last permitted PAD_WAIT cycle.
    sha256_ctrl_cnt #(
        .Width  (WdW),
        .MaxVal (TIMEOUT_CYCLES - 1)
    ) u_wd_cnt (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clr_i   (state_q == StPadStart),
        .en_i    ((state_q == StPadWait) && !wd_tc),
        .cnt_o   (wd_cnt),
        .tc_o    (wd_tc)
    );

    assign timeout = (state_q == StPadWait) && !pad_rdy_i && wd_tc;

    always_comb begin
        err_d = err_q;
        if (go_accept) begin
            err_d = 1'b0;
        end else if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_comb begin
        pad_len_d = pad_len_q;
        if (go_accept) begin
            pad_len_d = msg_len_i;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            pad_len_q <= '0;
        end else begin
            state_q   <= state_d;
            pad_len_q <= pad_len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: if (go_accept) state_d = StPadStart;
            StPadStart:     state_d = StPadWait;
            StPadWait: begin
                if (pad_rdy_i) begin
                    state_d = StLoad;
                end else if (timeout) begin
                    state_d = StIdle;
                end
            end
            StLoad:         state_d = StRound;
            StRound:        if (rnd_tc) state_d = StUpdate;
            StUpdate:       state_d = StWrite;
            StWrite:        if (wr_tc) state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    // Moore decode from registered state only; no input reaches an output combinationally.
    always_comb begin
        pad_go_o        = 1'b0;
        sched_load_o    = 1'b0;
        hash_init_o     = 1'b0;
        round_en_o      = 1'b0;
        hash_update_o   = 1'b0;
        out_mem_en_o    = 1'b0;
        out_mem_write_o = 1'b0;
        busy_o          = 1'b1;
        done_o          = 1'b0;
        case (state_q)
            StIdle:     busy_o = 1'b0;
            StPadStart: pad_go_o = 1'b1;
            StLoad: begin
                sched_load_o = 1'b1;
                hash_init_o  = 1'b1;
            end
            StRound:    round_en_o = 1'b1;
            StUpdate:   hash_update_o = 1'b1;
            StWrite: begin
                out_mem_en_o    = 1'b1;
                out_mem_write_o = 1'b1;
            end
            StDone: begin
                busy_o = 1'b0;
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign pad_len_o = pad_len_q;

endmodule

// File: tb/tb_sha256_ctrl.sv
// Directed self-checking bench for sha256_ctrl.
module tb_sha256_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       go_sig = 1'b0;
    logic [5:0] msg_len = '0;
    logic       pad_rdy = 1'b0;
    logic       pad_go, sched_load, hash_init, round_en, hash_update;
    logic       out_mem_en, out_mem_write, busy, done, err;
    logic [5:0] pad_len, round_idx;
    logic [2:0] out_mem_addr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    sha256_ctrl #(
        .MAX_MESSAGE_LENGTH (55),
        .TIMEOUT_CYCLES     (16)
    ) dut (
        .clock_i         (clock),
        .reset_i         (reset),
        .go_sig_i        (go_sig),
        .msg_len_i       (msg_len),
        .pad_go_o        (pad_go),
        .pad_len_o       (pad_len),
        .pad_rdy_i       (pad_rdy),
        .sched_load_o    (sched_load),
        .hash_init_o     (hash_init),
        .round_en_o      (round_en),
        .round_idx_o     (round_idx),
        .hash_update_o   (hash_update),
        .out_mem_en_o    (out_mem_en),
        .out_mem_write_o (out_mem_write),
        .out_mem_addr_o  (out_mem_addr),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err)
    );

    function automatic logic [24:0] all_outs();
        return {pad_go, sched_load, hash_init, round_en, hash_update, out_mem_en,
                out_mem_write, busy, done, err, pad_len, round_idx, out_mem_addr};
    endfunction

    // Pulses go from IDLE/DONE, returns pad_rdy after pdelay PAD_WAIT cycles and checks
    // the whole sequence; go_round >= 0 injects a go pulse at that round index.
    task automatic run_sequence(input logic [5:0] len, input int pdelay, input int go_round);
        int  rounds = 0, updates = 0, writes = 0, pgo = 0, loads = 0;
        int  first_round = -1, last_round = -1, upd_edge = -1, done_edge = -1;
        int  exp_r = 0, exp_w = 0;
        bit  injected = 0;
        go_sig  = 1'b1;
        msg_len = len;
        @(negedge clock);
        go_sig  = 1'b0;
        msg_len = ~len;
        n_cmp++;
        if ({pad_go, busy, done, err, pad_len} !== {1'b1, 1'b1, 1'b0, 1'b0, len}) begin
            n_err++;
            $display("FAIL start_state: {pad_go,busy,done,err,pad_len}=%b required %b",
                     {pad_go, busy, done, err, pad_len}, {1'b1, 1'b1, 1'b0, 1'b0, len});
        end
        for (int k = 1; k <= 200 && done_edge < 0; k++) begin
            @(negedge clock);
            if (injected && go_sig) go_sig = 1'b0;
            if (pad_go) pgo++;
            if (sched_load && hash_init) begin
                loads++;
                pad_rdy = 1'b0;
            end
            if (round_en) begin
                n_cmp++;
                if (round_idx !== exp_r[5:0]) begin
                    n_err++;
                    $display("FAIL round_idx: got %0d required %0d", round_idx, exp_r);
                end
                if (first_round < 0) first_round = k;
                last_round = k;
                rounds++;
                exp_r++;
                if (go_round >= 0 && !injected && int'(round_idx) == go_round) begin
                    go_sig   = 1'b1;
                    injected = 1;
                end
            end
            if (hash_update) begin
                updates++;
                upd_edge = k;
            end
            if (out_mem_write) begin
                n_cmp++;
                if ({out_mem_en, out_mem_addr} !== {1'b1, exp_w[2:0]}) begin
                    n_err++;
                    $display("FAIL write_addr: en/addr got %b/%0d required 1/%0d",
                             out_mem_en, out_mem_addr, exp_w);
                end
                writes++;
                exp_w++;
            end
            if (done) done_edge = k;
            if (k == pdelay) pad_rdy = 1'b1;
        end
        n_cmp++;
        if (done_edge !== 75 + pdelay) begin
            n_err++;
            $display("FAIL done_latency: got %0d required %0d", done_edge, 75 + pdelay);
        end
        n_cmp++;
        if ({rounds, first_round, last_round} !== {32'd64, pdelay + 2, pdelay + 65}) begin
            n_err++;
            $display("FAIL round_window: count/first/last got %0d/%0d/%0d required 64/%0d/%0d",
                     rounds, first_round, last_round, pdelay + 2, pdelay + 65);
        end
        n_cmp++;
        if ({updates, upd_edge, writes, pgo, loads} !== {32'd1, pdelay + 66, 32'd8, 32'd0, 32'd1})
        begin
            n_err++;
            $display("FAIL strobe_counts: upd/upd_edge/wr/extra_pad_go/load got %0d/%0d/%0d/%0d/%0d",
                     updates, upd_edge, writes, pgo, loads);
        end
        n_cmp++;
        if ({busy, err, pad_len, round_idx, out_mem_addr} !== {1'b0, 1'b0, len, 6'd63, 3'd7}) begin
            n_err++;
            $display("FAIL done_state: busy/err/pad_len/ridx/addr got %b/%b/%0d/%0d/%0d",
                     busy, err, pad_len, round_idx, out_mem_addr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (all_outs() !== 25'd0) begin
            n_err++;
            $display("FAIL reset_held: outputs %h required 0", all_outs());
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_cmp++;
        if (all_outs() !== 25'd0) begin
            n_err++;
            $display("FAIL reset_released: outputs %h required 0", all_outs());
        end
    endtask

    task automatic test_go_pulse();
        run_sequence(6'd7, 1, -1);
    endtask

    task automatic test_full_run();
        run_sequence(6'd33, 5, -1);
    endtask

    task automatic test_go_during_round();
        run_sequence(6'd12, 3, 20);
    endtask

    task automatic test_reset_during_write();
        int k = 0;
        int wr = 0;
        go_sig  = 1'b1;
        msg_len = 6'd21;
        pad_rdy = 1'b1;
        @(negedge clock);
        go_sig = 1'b0;
        while (!(out_mem_write && out_mem_addr == 3'd3) && k < 200) begin
            @(negedge clock);
            k++;
        end
        n_cmp++;
        if (k >= 200) begin
            n_err++;
            $display("FAIL reach_write3: got timeout required write at addr 3");
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (all_outs() !== 25'd0) begin
            n_err++;
            $display("FAIL async_reset: outputs %h required 0", all_outs());
        end
        pad_rdy = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (out_mem_write) wr++;
        end
        reset = 1'b0;
        @(negedge clock);
        if (out_mem_write) wr++;
        n_cmp++;
        if ({wr, busy, done} !== {32'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL after_reset: writes/busy/done got %0d/%b/%b required 0/0/0",
                     wr, busy, done);
        end
        run_sequence(6'd2, 1, -1);
    endtask

    task automatic test_back_to_back();
        run_sequence(6'd54, 2, -1);
        run_sequence(6'd40, 1, -1);
    endtask

    task automatic test_pad_wait();
`ifdef SHA_CTRL_TIMEOUT_EN
        int k = 0;
        go_sig  = 1'b1;
        msg_len = 6'd9;
        pad_rdy = 1'b0;
        @(negedge clock);
        go_sig = 1'b0;
        while (busy && k < 100) begin
            @(negedge clock);
            k++;
        end
        n_cmp++;
        if ({k, err, done} !== {32'd17, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL watchdog: idle_edge/err/done got %0d/%b/%b required 17/1/0",
                     k, err, done);
        end
        run_sequence(6'd9, 4, -1);
`else
        run_sequence(6'd9, 40, -1);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_go_pulse();
        test_full_run();
        test_go_during_round();
        test_reset_during_write();
        test_back_to_back();
        test_pad_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sha256_ctrl.md
# sha256_ctrl

Top-level sequencer for the SHA256 accelerator's single-block datapath. On a start pulse it launches the padded-message generator and waits for the padded block. It then loads the message schedule and working registers, steps the compression core through 64 rounds, and folds the result into the hash state. Finally it writes the eight 32-bit digest words to the output SRAM and reports completion.

## Interface
- MAX_MESSAGE_LENGTH, 55: maximum message length in bytes (single 512-bit block); sets LEN_W = $clog2(MAX_MESSAGE_LENGTH).
- TIMEOUT_CYCLES, 256: padder watchdog limit; used only with SHA_CTRL_TIMEOUT_EN.

- clock  in  1  rising-edge clock for all state.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- go_sig  in  1  start request; sampled in IDLE and DONE only.
- msg_len  in  LEN_W  message length in bytes; captured on an accepted go_sig.
- pad_go  out  1  one-cycle start pulse to the padded-message generator.
- pad_len  out  LEN_W  latched msg_len, held stable from go acceptance until the next accepted go.
- pad_rdy  in  1  padded block valid; level from padder.
- sched_load  out  1  load the 512-bit padded block into the W schedule.
- hash_init  out  1  load IV H0..H7 into working registers a..h.
- round_en  out  1  compression core advances one round.
- round_idx  out  6  current round number; selects K[t] and W[t].
- hash_update  out  1  H[i] <= H[i] + working[i], all i.
- out_mem_en  out  1  output SRAM enable.
- out_mem_write  out  1  output SRAM write strobe.
- out_mem_addr  out  3  digest word index; also the H-word select.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  level; high in DONE.
- err  out  1  watchdog fired; sticky until the next accepted go. Constant 0 without SHA_CTRL_TIMEOUT_EN.

## Operation
- States: IDLE, PAD_START, PAD_WAIT, LOAD, ROUND, UPDATE, WRITE, DONE.
- IDLE/DONE + go_sig=1 -> PAD_START. The same edge latches pad_len and clears done and err.
- PAD_START: pad_go=1 for exactly 1 cycle -> PAD_WAIT.
- PAD_WAIT: hold until pad_rdy=1, then -> LOAD. pad_rdy is ignored in every other state.
- LOAD: sched_load=1 and hash_init=1 for 1 cycle; round counter cleared -> ROUND.
- ROUND: round_en=1 and round_idx=0..63, one round per cycle. On round_idx==63 -> UPDATE.
- UPDATE: hash_update=1 for 1 cycle; write counter cleared -> WRITE.
- WRITE: out_mem_en=1, out_mem_write=1, out_mem_addr=0..7. On addr==7 -> DONE.
- DONE: done=1 until an accepted go_sig.
- go_sig while busy is ignored: no queuing, no restart.
- msg_len is not range-checked. The padder owns length handling.
- All strobe outputs are 0 outside their own state. round_idx and out_mem_addr hold their last value when not in use.
- Counters are 6-bit (round) and 3-bit (write). The terminal count is decoded, never left to wrap; the counter clears on state entry.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE; every output 0, including pad_len and round_idx.
- Reset mid-operation aborts immediately. No partial digest is written after reset asserts.
- Latency from the go_sig edge to the done rising edge: 1 (PAD_START) + P (cycles in PAD_WAIT, minimum 1) + 1 + 64 + 1 + 8 = 75 + P cycles.
- pad_rdy already high on PAD_WAIT entry gives P=1.
- go_sig in DONE restarts directly: done drops on the next edge, and busy rises on that same edge.
- All outputs are registered, decoded from state and counters with no input-to-output combinational path.

## Configuration
- SHA_CTRL_TIMEOUT_EN defined: a watchdog counts cycles in PAD_WAIT. If the count reaches TIMEOUT_CYCLES without pad_rdy, the controller goes to IDLE and sets err=1; done stays 0.
- SHA_CTRL_TIMEOUT_EN undefined: PAD_WAIT waits indefinitely, err is tied to 0, and no watchdog logic is generated.

## Structure
- The shared package sha256_ctrl_pkg holds:
  - the state enum type;
  - the constants SHA_ROUNDS=64 and SHA_HASH_WORDS=8;
  - the round/address widths.
- One sub-module, sha256_ctrl_cnt: a parameterised up-counter with synchronous clear, enable and a terminal-count flag. It is instantiated for the round, write and (optionally) watchdog counters.

## Test plan
- Reset held, then released -> all outputs 0, state IDLE. A go_sig pulse with msg_len=7 -> pad_go high exactly one cycle later for one cycle, and pad_len=7.
- Full run with pad_rdy returned 5 cycles after pad_go -> round_en high 64 consecutive cycles with round_idx 0..63, then one hash_update, then writes to addresses 0..7. done rises at cycle 75+P after go (P=5 here).
- go_sig pulsed during ROUND (round_idx=20) -> no effect; the sequence and latency are unchanged.
- Reset asserted during WRITE at addr=3 -> outputs 0 asynchronously, no further writes. A following go_sig runs a clean full sequence.
- go_sig in DONE -> done falls and busy rises on the next edge, and a second full sequence completes.
- With SHA_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16, pad_rdy never asserted -> return to IDLE after 16 cycles in PAD_WAIT with err=1 and done=0. The next go_sig clears err.
